// File: rtl/fifo_push_arb_if.sv
// fifo_push_arb_if: requester/FIFO push bundle
// master drives requests, slave returns grants
interface fifo_push_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        last;
  logic [NUM_REQ*DATA_W-1:0] wdata;
  logic                      full_ff;
  logic [NUM_REQ-1:0]        gnt;
  logic                      push;
  logic [DATA_W-1:0]         push_data;
  logic [SRC_W-1:0]          push_src;
  logic                      err_len;

  modport master (
    output req, last, wdata, full_ff,
    input  gnt, push, push_data,
    input  push_src, err_len
  );

  modport slave (
    input  req, last, wdata, full_ff,
    output gnt, push, push_data,
    output push_src, err_len
  );
endinterface

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: packet-locking round-robin arbiter
// onto a single FIFO push port
module fifo_push_arb #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_push_arb_if.slave   bus
);
  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   w_rr_nxt;
  logic [SRC_W-1:0]   r_owner;
  logic [SRC_W-1:0]   w_owner_nxt;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic               r_err_len;
  logic               w_err_nxt;
  logic               w_found;
  logic [SRC_W-1:0]   w_win;
  logic [SRC_W-1:0]   w_src;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_push;
  logic [DATA_W-1:0]  w_data;

  function automatic logic [SRC_W-1:0] f_inc(
    input logic [SRC_W-1:0] i
  );
    if (i == SRC_W'(NUM_REQ - 1))
      return '0;
    return i + SRC_W'(1);
  endfunction

  assign w_cnt_inc = r_beat_cnt + CNT_W'(1);

  // State register; reset abandons any open packet
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
      r_err_len  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_err_len  <= w_err_nxt;
    end
  end

  // Round-robin search from rr_ptr; lowest offset wins
  always_comb begin
    logic [SRC_W-1:0] idx;
    int v;
    w_found = 1'b0;
    w_win   = '0;
    idx     = '0;
    v       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      v = int'(r_rr_ptr) + k;
      if (v >= NUM_REQ)
        v = v - NUM_REQ;
      idx = SRC_W'(v);
      if (bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  // Next state: only a granted beat moves the FSM
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_beat_cnt;
    w_err_nxt   = 1'b0;
    if (w_push) begin
      unique case (r_state)
        IDLE: begin
          if (bus.last[w_win]) begin
            w_rr_nxt = f_inc(w_win);
          end else begin
            w_state_nxt = LOCKED;
            w_owner_nxt = w_win;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        LOCKED: begin
          if (bus.last[r_owner]) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = f_inc(r_owner);
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc ==
                       CNT_W'(MAX_BEATS)) begin
            w_state_nxt = IDLE;
            w_rr_nxt    = f_inc(r_owner);
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      endcase
    end
  end

  // Grant outputs; full or reset blocks every push
  always_comb begin
    w_gnt = '0;
    w_src = '0;
    if (!rst && !bus.full_ff) begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            w_gnt[w_win] = 1'b1;
            w_src        = w_win;
          end
        end
        LOCKED: begin
          if (bus.req[r_owner]) begin
            w_gnt[r_owner] = 1'b1;
            w_src          = r_owner;
          end
        end
      endcase
    end
  end

  assign w_push = |w_gnt;
  assign w_data = w_push ?
    bus.wdata[w_src*DATA_W +: DATA_W] : '0;

  assign bus.gnt       = w_gnt;
  assign bus.push      = w_push;
  assign bus.push_data = w_data;
  assign bus.push_src  = w_src;
  assign bus.err_len   = r_err_len;
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: scenario bench with
// expected-grant scoreboard queue
module tb_fifo_push_arb;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  typedef struct packed {
    logic       rs;
    logic [3:0] r;
    logic [3:0] l;
    logic       f;
    logic       p;
    logic [1:0] s;
    logic       e;
  } cyc_t;

  logic [1:0] exp_q[$];

  fifo_push_arb_if #(
    .NUM_REQ(4),
    .DATA_W (32)
  ) bus ();

  fifo_push_arb #(
    .NUM_REQ  (4),
    .DATA_W   (32),
    .MAX_BEATS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dval(
    input logic [1:0] i
  );
    return 32'hC0DE_0000 +
      32'(i) * 32'h0111_0101;
  endfunction

  function automatic cyc_t mk(
    input logic rs, input logic [3:0] r,
    input logic [3:0] l, input logic f,
    input logic p, input logic [1:0] s,
    input logic e
  );
    cyc_t c;
    c = {rs, r, l, f, p, s, e};
    return c;
  endfunction

  task automatic apply(input cyc_t c);
    rst         = c.rs;
    bus.req     = c.r;
    bus.last    = c.l;
    bus.full_ff = c.f;
    if (c.p)
      exp_q.push_back(c.s);
  endtask

  task automatic test_reset();
    apply(mk(1, 4'hF, 4'hF, 0, 0, 0, 0));
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'h0 || bus.push !== 1'b0) begin
      errors++;
      $display("FAIL reset gnt=%b push=%b exp 0000/0",
               bus.gnt, bus.push);
    end
    checks++;
    if (bus.push_data !== 32'h0 ||
        bus.push_src !== 2'd0) begin
      errors++;
      $display("FAIL reset data=%h src=%0d exp 0/0",
               bus.push_data, bus.push_src);
    end
    checks++;
    if (bus.err_len !== 1'b0) begin
      errors++;
      $display("FAIL reset err_len=%b exp 0",
               bus.err_len);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rotate();
    cyc_t t[$];
    logic [1:0] s;
    for (int i = 0; i < 8; i++)
      t.push_back(mk(0, 4'hF, 4'hF, 0, 1,
                     2'(i), 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL rotate c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL rotate c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_packet();
    cyc_t t[$];
    logic [1:0] s;
    t.push_back(mk(0, 4'hF, 4'hB, 0, 1, 0, 0));
    t.push_back(mk(0, 4'hF, 4'hB, 0, 1, 1, 0));
    t.push_back(mk(0, 4'hF, 4'hB, 0, 1, 2, 0));
    t.push_back(mk(0, 4'hF, 4'hB, 0, 1, 2, 0));
    t.push_back(mk(0, 4'hF, 4'hF, 0, 1, 2, 0));
    t.push_back(mk(0, 4'hF, 4'hF, 0, 1, 3, 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL packet c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL packet c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_stall();
    cyc_t t[$];
    logic [1:0] s;
    t.push_back(mk(0, 4'h2, 4'h0, 0, 1, 1, 0));
    t.push_back(mk(0, 4'h2, 4'h0, 1, 0, 0, 0));
    t.push_back(mk(0, 4'h3, 4'h0, 1, 0, 0, 0));
    t.push_back(mk(0, 4'h3, 4'h1, 0, 1, 1, 0));
    t.push_back(mk(0, 4'h1, 4'h1, 0, 0, 0, 0));
    t.push_back(mk(0, 4'h2, 4'h2, 0, 1, 1, 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL full_stall c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL full_stall c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end else begin
        checks++;
        if (bus.gnt !== 4'h0) begin
          errors++;
          $display("FAIL full_stall c%0d gnt=%b exp 0000",
                   k, bus.gnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_max_beats();
    cyc_t t[$];
    logic [1:0] s;
    for (int i = 0; i < 4; i++)
      t.push_back(mk(0, 4'h3, 4'h2, 0, 1, 0, 0));
    t.push_back(mk(0, 4'h3, 4'h2, 0, 1, 1, 1));
    t.push_back(mk(0, 4'h1, 4'h0, 0, 1, 0, 0));
    t.push_back(mk(0, 4'h1, 4'h1, 0, 1, 0, 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL max_beats c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL max_beats c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    cyc_t t[$];
    logic [1:0] s;
    t.push_back(mk(0, 4'h8, 4'h0, 0, 1, 3, 0));
    t.push_back(mk(0, 4'h8, 4'h0, 0, 1, 3, 0));
    t.push_back(mk(1, 4'hA, 4'h0, 0, 0, 0, 0));
    t.push_back(mk(0, 4'hA, 4'hA, 0, 1, 1, 0));
    t.push_back(mk(0, 4'hA, 4'hA, 0, 1, 3, 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL reset_mid c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL reset_mid c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end else begin
        checks++;
        if (bus.gnt !== 4'h0 ||
            bus.push_data !== 32'h0) begin
          errors++;
          $display("FAIL reset_mid c%0d gnt=%b data=%h exp 0",
                   k, bus.gnt, bus.push_data);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_full_after_reset();
    cyc_t t[$];
    logic [1:0] s;
    t.push_back(mk(1, 4'h1, 4'h1, 1, 0, 0, 0));
    t.push_back(mk(0, 4'h1, 4'h1, 1, 0, 0, 0));
    t.push_back(mk(0, 4'h1, 4'h1, 1, 0, 0, 0));
    t.push_back(mk(0, 4'h1, 4'h1, 0, 1, 0, 0));
    t.push_back(mk(0, 4'h0, 4'h0, 0, 0, 0, 0));
    foreach (t[k]) begin
      apply(t[k]);
      @(negedge clk);
      checks++;
      if (bus.push !== t[k].p ||
          bus.err_len !== t[k].e) begin
        errors++;
        $display("FAIL full_reset c%0d push=%b err=%b exp %b/%b",
                 k, bus.push, bus.err_len, t[k].p, t[k].e);
      end
      if (t[k].p) begin
        s = exp_q.pop_front();
        checks++;
        if (bus.push_src !== s ||
            bus.gnt !== (4'b1 << s) ||
            bus.push_data !== dval(s)) begin
          errors++;
          $display("FAIL full_reset c%0d src=%0d gnt=%b data=%h exp src %0d",
                   k, bus.push_src, bus.gnt,
                   bus.push_data, s);
        end
      end else begin
        checks++;
        if (bus.gnt !== 4'h0) begin
          errors++;
          $display("FAIL full_reset c%0d gnt=%b exp 0000",
                   k, bus.gnt);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.req     = '0;
    bus.last    = '0;
    bus.full_ff = 1'b1;
    for (int i = 0; i < 4; i++)
      bus.wdata[i*32 +: 32] = dval(2'(i));
    test_reset();
    test_rotate();
    test_packet();
    test_full_stall();
    test_max_beats();
    test_reset_mid();
    test_full_after_reset();
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one FIFO push port; legal range 2..8.
REQ-002 Parameter DATA_W, default 32: width of each requester's write data.
REQ-003 Parameter MAX_BEATS, default 16: maximum beats per packet before forced release; legal range 2..256.
REQ-004 Clocking and reset: single clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1: the single clock; the FIFO push side (clk_push) is driven from this clock.
REQ-006 Port rst, input, 1: synchronous, active-high reset.
REQ-007 Port req, input, NUM_REQ: per-requester beat request.
REQ-008 Port last, input, NUM_REQ: per-requester end-of-packet marker, qualified by req.
REQ-009 Port wdata, input, NUM_REQ*DATA_W: per-requester data; requester i uses bits [i*DATA_W +: DATA_W].
REQ-010 Port full_ff, input, 1: FIFO full flag; 1 blocks every push.
REQ-011 Port gnt, output, NUM_REQ: one-hot beat accept; at most one bit set.
REQ-012 Port push, output, 1: FIFO push strobe; equals OR of gnt.
REQ-013 Port push_data, output, DATA_W: wdata of the granted requester; 0 when push=0.
REQ-014 Port push_src, output, dfafn_range2size(NUM_REQ): index of the granted requester; 0 when push=0.
REQ-015 Port err_len, output, 1: one-cycle pulse when a packet is force-released at MAX_BEATS.

Function
REQ-016 Beat transfer: a beat is transferred in the cycle where gnt[i]=1; gnt, push, push_data and push_src are combinational from registered state, req, last and full_ff, with zero cycles of latency.
REQ-017 full_ff=1: all gnt bits SHALL be 0 and push SHALL be 0; registered state SHALL hold, except under reset.
REQ-018 Requester obligation: a requester holds req, last and wdata stable until granted; the block SHALL NOT depend on this for safety.
REQ-019 Registered state: FSM state (IDLE, LOCKED), rr_ptr (round-robin start index), owner index, and beat_cnt (counts up to MAX_BEATS).
REQ-020 IDLE arbitration: winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
REQ-021 IDLE, no req or full_ff=1: no grant; state unchanged.
REQ-022 IDLE, winner w and last[w]=1: single-beat packet; stay IDLE; rr_ptr <= (w+1) mod NUM_REQ.
REQ-023 IDLE, winner w and last[w]=0: enter LOCKED; owner <= w; beat_cnt <= 1.
REQ-024 LOCKED: gnt[owner] = req[owner] & !full_ff; all other gnt bits SHALL be 0, regardless of their req.
REQ-025 LOCKED, req[owner]=0: stall indefinitely; ownership is kept.
REQ-026 LOCKED, granted beat with last[owner]=1: go to IDLE; rr_ptr <= (owner+1) mod NUM_REQ; beat_cnt <= 0.
REQ-027 LOCKED, granted beat with last=0 and beat_cnt+1 = MAX_BEATS: force release to IDLE; rr_ptr <= (owner+1) mod NUM_REQ; err_len=1 in the following cycle for exactly one cycle.
REQ-028 LOCKED, granted beat otherwise: beat_cnt <= beat_cnt+1.
REQ-029 Wrap-around: rr_ptr and owner increment modulo NUM_REQ; a requester at index NUM_REQ-1 that wins SHALL set rr_ptr to 0.
REQ-030 Fairness: with all requesters continuously requesting single-beat packets and full_ff=0, grants SHALL rotate 0,1,…,NUM_REQ-1,0,…
REQ-031 No FIFO overrun: push=1 with full_ff=1 is prohibited in every state.

Reset
REQ-032 When rst=1 at a clk edge, the following SHALL be set: state <= IDLE, rr_ptr <= 0, owner <= 0, beat_cnt <= 0, err_len <= 0.
REQ-033 During rst=1, gnt, push, push_data and push_src SHALL be 0 combinationally.
REQ-034 Reset asserted while LOCKED SHALL abandon the packet; the first grant after reset SHALL follow REQ-020 with rr_ptr=0.
REQ-035 FIFO comes out of reset with full_ff=1; no grant SHALL occur until full_ff=0.

Verification
REQ-036 Scenario: NUM_REQ=4, req=4'b1111, last=4'b1111, full_ff=0 for 8 cycles -> push_src sequence 0,1,2,3,0,1,2,3.
REQ-037 Scenario: req[2] sends a 3-beat packet (last on beat 3) while req=4'b1111 -> gnt=4'b0100 for 3 consecutive beats, then the next grant goes to index 3.
REQ-038 Scenario: LOCKED owner=1; at beat 2, full_ff=1 for 2 cycles -> gnt=0, push=0 for those cycles; beat 2 is accepted on the first cycle with full_ff=0; owner unchanged.
REQ-039 Scenario: MAX_BEATS=4; requester 0 holds req=1, last=0 -> exactly 4 grants, then err_len pulses 1 cycle, and the next grant goes to requester 1 if req[1]=1.
REQ-040 Scenario: rst=1 mid-packet (owner=3, beat_cnt=2), then req=4'b1010 -> first grant after reset to index 1, then to index 3.
REQ-041 Scenario: after reset with full_ff=1 and req=4'b0001 -> no push until full_ff falls, then gnt=4'b0001 in that same cycle.
